// File: rtl/axil_csr_bank.sv
// axil_csr_bank: AXI-Lite control/status register bank.
//
// Word-addressed map (index = addr >> log2(DATA_W/8)):
//   0 .. CTRL-1           control registers, RW, byte-masked writes
//   CTRL .. CTRL+STAT-1   status inputs, RO, sampled at AR handshake
//   R   = CTRL+STAT       IRQ_EN, RW           (present when INTERRUPTS > 0)
//   R+1                   IRQ_STAT, R/W1C
//   R+2                   IRQ_PEND = IRQ_STAT & IRQ_EN, RO
//
// Ports:
//   i_aclk, i_areset                      clock, synchronous active-high reset
//   i_aw_* / o_aw_ready                   write address channel
//   i_w_*  / o_w_ready                    write data channel
//   o_b_valid, i_b_ready, o_b_resp        write response channel
//   i_ar_* / o_ar_ready                   read address channel
//   o_r_valid, i_r_ready, o_r_data/resp   read data channel
//   o_ctrl        CTRL x DATA_W control register contents
//   o_write_ctrl  per-byte write strobes of ctrl registers, one-cycle pulse
//   i_stat        STAT x DATA_W status inputs
//   i_interrupts  interrupt sources
//   o_irq         registered OR of pending interrupts
//
// Write FSM:
//   state    | meaning
//   W_IDLE   | collecting AW and W handshakes, in any order
//   W_COMMIT | one cycle: apply data to target, decide response
//   W_RESP   | bValid held until bReady
// Read FSM:
//   state    | meaning
//   R_IDLE   | arReady high, waiting for AR
//   R_DATA   | rValid held until rReady

module axil_csr_bank #(
    parameter int                     DATA_W     = 32,
    parameter int                     ADDR_W     = 12,
    parameter int                     CTRL       = 4,
    parameter int                     STAT       = 4,
    parameter int                     INTERRUPTS = 8,
    parameter logic [DATA_W-1:0]      IRQ_EDGE   = '0,
    parameter logic [CTRL*DATA_W-1:0] CTRL_RESET = '0,
    parameter bit                     ERR_RESP   = 1'b1
) (
    input  logic                                    i_aclk,
    input  logic                                    i_areset,
    input  logic                                    i_aw_valid,
    output logic                                    o_aw_ready,
    input  logic [ADDR_W-1:0]                       i_aw_addr,
    input  logic                                    i_w_valid,
    output logic                                    o_w_ready,
    input  logic [DATA_W-1:0]                       i_w_data,
    input  logic [DATA_W/8-1:0]                     i_w_strb,
    output logic                                    o_b_valid,
    input  logic                                    i_b_ready,
    output logic [1:0]                              o_b_resp,
    input  logic                                    i_ar_valid,
    output logic                                    o_ar_ready,
    input  logic [ADDR_W-1:0]                       i_ar_addr,
    output logic                                    o_r_valid,
    input  logic                                    i_r_ready,
    output logic [DATA_W-1:0]                       o_r_data,
    output logic [1:0]                              o_r_resp,
    output logic [CTRL*DATA_W-1:0]                  o_ctrl,
    output logic [CTRL*DATA_W/8-1:0]                o_write_ctrl,
    input  logic [(STAT>0 ? STAT : 1)*DATA_W-1:0]   i_stat,
    input  logic [(INTERRUPTS>0 ? INTERRUPTS : 1)-1:0] i_interrupts,
    output logic                                    o_irq
);

    localparam int STRB_W     = DATA_W / 8;
    localparam int ADDR_LSB   = $clog2(STRB_W);
    localparam int IDX_W      = ADDR_W - ADDR_LSB;
    localparam bit HAS_IRQ    = (INTERRUPTS > 0);
    localparam int R_IRQ_EN   = CTRL + STAT;
    localparam int R_IRQ_STAT = CTRL + STAT + 1;
    localparam int R_IRQ_PEND = CTRL + STAT + 2;
    localparam logic [DATA_W-1:0] IRQ_MASK =
        (INTERRUPTS == 0) ? '0 : ({DATA_W{1'b1}} >> (DATA_W - INTERRUPTS));

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // ---------------- write path ----------------
    wstate_t             r_wstate, w_wstate_nxt;
    logic                r_aw_ready, r_w_ready, r_aw_held, r_w_held;
    logic                w_aw_ready_nxt, w_w_ready_nxt, w_aw_held_nxt, w_w_held_nxt;
    logic                w_aw_hs, w_w_hs, w_commit;
    logic [IDX_W-1:0]    r_aw_idx;
    logic [DATA_W-1:0]   r_w_data;
    logic [STRB_W-1:0]   r_w_strb;
    logic [DATA_W-1:0]   w_wmask;
    logic [31:0]         w_aw_idx;
    logic                w_wr_ctrl, w_wr_en, w_wr_st, w_wr_ok;
    logic [1:0]          r_b_resp;
    logic [DATA_W-1:0]   r_ctrl [CTRL];
    logic [CTRL*STRB_W-1:0] r_write_ctrl;

    assign w_aw_hs  = i_aw_valid & r_aw_ready;
    assign w_w_hs   = i_w_valid & r_w_ready;
    assign w_commit = (r_wstate == W_COMMIT);

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_aw_ready_nxt = r_aw_ready;
        w_w_ready_nxt  = r_w_ready;
        w_aw_held_nxt  = r_aw_held;
        w_w_held_nxt   = r_w_held;
        case (r_wstate)
            W_IDLE: begin
                w_aw_held_nxt  = r_aw_held | w_aw_hs;
                w_w_held_nxt   = r_w_held | w_w_hs;
                w_aw_ready_nxt = ~w_aw_held_nxt;
                w_w_ready_nxt  = ~w_w_held_nxt;
                if (w_aw_held_nxt && w_w_held_nxt) w_wstate_nxt = W_COMMIT;
            end
            W_COMMIT: begin
                w_wstate_nxt   = W_RESP;
                w_aw_held_nxt  = 1'b0;
                w_w_held_nxt   = 1'b0;
                w_aw_ready_nxt = 1'b0;
                w_w_ready_nxt  = 1'b0;
            end
            W_RESP: begin
                if (i_b_ready) begin
                    w_wstate_nxt   = W_IDLE;
                    w_aw_ready_nxt = 1'b1;
                    w_w_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_wstate_nxt   = W_IDLE;
                w_aw_held_nxt  = 1'b0;
                w_w_held_nxt   = 1'b0;
                w_aw_ready_nxt = 1'b0;
                w_w_ready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_wstate   <= W_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_aw_ready <= w_aw_ready_nxt;
            r_w_ready  <= w_w_ready_nxt;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_aw_hs) r_aw_idx <= i_aw_addr[ADDR_W-1:ADDR_LSB];
        if (w_w_hs) begin
            r_w_data <= i_w_data;
            r_w_strb <= i_w_strb;
        end
    end

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < STRB_W; b++) w_wmask[b*8 +: 8] = {8{r_w_strb[b]}};
    end

    assign w_aw_idx  = 32'(r_aw_idx);
    assign w_wr_ctrl = (w_aw_idx < CTRL);
    assign w_wr_en   = HAS_IRQ && (w_aw_idx == 32'(R_IRQ_EN));
    assign w_wr_st   = HAS_IRQ && (w_aw_idx == 32'(R_IRQ_STAT));
    assign w_wr_ok   = w_wr_ctrl | w_wr_en | w_wr_st;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_b_resp     <= 2'b00;
            r_write_ctrl <= '0;
            for (int i = 0; i < CTRL; i++) r_ctrl[i] <= CTRL_RESET[i*DATA_W +: DATA_W];
        end else begin
            r_write_ctrl <= '0;
            if (w_commit) begin
                r_b_resp <= (!w_wr_ok && ERR_RESP) ? 2'b10 : 2'b00;
                for (int i = 0; i < CTRL; i++) begin
                    if (w_wr_ctrl && (w_aw_idx == 32'(i))) begin
                        r_ctrl[i] <= (r_ctrl[i] & ~w_wmask) | (r_w_data & w_wmask);
                        r_write_ctrl[i*STRB_W +: STRB_W] <= r_w_strb;
                    end
                end
            end
        end
    end

    assign o_aw_ready   = r_aw_ready;
    assign o_w_ready    = r_w_ready;
    assign o_b_valid    = (r_wstate == W_RESP);
    assign o_b_resp     = r_b_resp;
    assign o_write_ctrl = r_write_ctrl;

    for (genvar g = 0; g < CTRL; g++) begin : g_ctrl_out
        assign o_ctrl[g*DATA_W +: DATA_W] = r_ctrl[g];
    end

    // ---------------- interrupts ----------------
    logic [DATA_W-1:0] r_irq_en, r_irq_stat, r_prev;
    logic [DATA_W-1:0] w_src, w_event, w_w1c, w_irq_en_nxt, w_irq_stat_nxt;
    logic              r_irq;

    assign w_src   = DATA_W'(i_interrupts) & IRQ_MASK;
    assign w_event = ((w_src & ~r_prev & IRQ_EDGE) | (w_src & ~IRQ_EDGE)) & IRQ_MASK;
    assign w_w1c   = (w_commit && w_wr_st) ? (r_w_data & w_wmask) : '0;

    // A new event in the same cycle as a W1C wins: clear first, then set.
    assign w_irq_stat_nxt = ((r_irq_stat & ~w_w1c) | (w_event & r_irq_en)) & IRQ_MASK;
    assign w_irq_en_nxt   = (w_commit && w_wr_en)
                          ? (((r_irq_en & ~w_wmask) | (r_w_data & w_wmask)) & IRQ_MASK)
                          : r_irq_en;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_prev     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_en   <= w_irq_en_nxt;
            r_irq_stat <= w_irq_stat_nxt;
            r_prev     <= w_src;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    assign o_irq = r_irq;

    // ---------------- read path ----------------
    rstate_t           r_rstate, w_rstate_nxt;
    logic              r_ar_ready, w_ar_ready_nxt, w_ar_hs;
    logic [31:0]       w_ar_idx;
    logic [DATA_W-1:0] w_rd_data, r_r_data;
    logic              w_rd_hit;
    logic [1:0]        r_r_resp;

    assign w_ar_hs  = i_ar_valid & r_ar_ready;
    assign w_ar_idx = 32'(i_ar_addr[ADDR_W-1:ADDR_LSB]);

    always_comb begin
        w_rstate_nxt   = r_rstate;
        w_ar_ready_nxt = r_ar_ready;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_nxt   = R_DATA;
                    w_ar_ready_nxt = 1'b0;
                end else begin
                    w_ar_ready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (i_r_ready) begin
                    w_rstate_nxt   = R_IDLE;
                    w_ar_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_rstate_nxt   = R_IDLE;
                w_ar_ready_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        for (int i = 0; i < CTRL; i++) begin
            if (w_ar_idx == 32'(i)) begin
                w_rd_data = r_ctrl[i];
                w_rd_hit  = 1'b1;
            end
        end
        for (int i = 0; i < STAT; i++) begin
            if (w_ar_idx == 32'(CTRL + i)) begin
                w_rd_data = i_stat[i*DATA_W +: DATA_W];
                w_rd_hit  = 1'b1;
            end
        end
        if (HAS_IRQ) begin
            if (w_ar_idx == 32'(R_IRQ_EN)) begin
                w_rd_data = r_irq_en;
                w_rd_hit  = 1'b1;
            end
            if (w_ar_idx == 32'(R_IRQ_STAT)) begin
                w_rd_data = r_irq_stat;
                w_rd_hit  = 1'b1;
            end
            if (w_ar_idx == 32'(R_IRQ_PEND)) begin
                w_rd_data = r_irq_stat & r_irq_en;
                w_rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_rstate   <= R_IDLE;
            r_ar_ready <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= 2'b00;
        end else begin
            r_rstate   <= w_rstate_nxt;
            r_ar_ready <= w_ar_ready_nxt;
            if (w_ar_hs) begin
                r_r_data <= w_rd_data;
                r_r_resp <= (!w_rd_hit && ERR_RESP) ? 2'b10 : 2'b00;
            end
        end
    end

    assign o_ar_ready = r_ar_ready;
    assign o_r_valid  = (r_rstate == R_DATA);
    assign o_r_data   = r_r_data;
    assign o_r_resp   = r_r_resp;

    // Sub-word address bits never select anything.
    logic w_unused;
    assign w_unused = ^{i_aw_addr[ADDR_LSB-1:0], i_ar_addr[ADDR_LSB-1:0], i_stat};

endmodule

// File: tb/tb_axil_csr_bank.sv
module tb_axil_csr_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam logic [127:0] CRST = {32'h0, 32'h0, 32'h0, 32'h1234_5678};

    logic         clk = 1'b0;
    logic         areset;
    logic         aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic         ar_valid, ar_ready, r_valid, r_ready, irq;
    logic [11:0]  aw_addr, ar_addr;
    logic [31:0]  w_data, r_data;
    logic [3:0]   w_strb;
    logic [1:0]   b_resp, r_resp;
    logic [127:0] ctrl, stat;
    logic [15:0]  write_ctrl;
    logic [7:0]   interrupts;

    int n_checks = 0;
    int n_fail   = 0;
    int wc_pulses = 0;

    always #5 clk = ~clk;

    axil_csr_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL(4), .STAT(4), .INTERRUPTS(8),
        .IRQ_EDGE(32'h0000_0002), .CTRL_RESET(CRST), .ERR_RESP(1'b1)
    ) dut (
        .i_aclk(clk), .i_areset(areset),
        .i_aw_valid(aw_valid), .o_aw_ready(aw_ready), .i_aw_addr(aw_addr),
        .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data), .i_w_strb(w_strb),
        .o_b_valid(b_valid), .i_b_ready(b_ready), .o_b_resp(b_resp),
        .i_ar_valid(ar_valid), .o_ar_ready(ar_ready), .i_ar_addr(ar_addr),
        .o_r_valid(r_valid), .i_r_ready(r_ready), .o_r_data(r_data), .o_r_resp(r_resp),
        .o_ctrl(ctrl), .o_write_ctrl(write_ctrl), .i_stat(stat),
        .i_interrupts(interrupts), .o_irq(irq)
    );

    always @(negedge clk) if (write_ctrl != 16'h0) wc_pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Both handshakes; returns one step into the COMMIT cycle.
    task automatic aw_w_send(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic da, dw, ha, hw;
        aw_valid = 1'b1; aw_addr = a;
        w_valid  = 1'b1; w_data = d; w_strb = s;
        da = 1'b0; dw = 1'b0;
        for (int n = 0; n < 16 && !(da && dw); n++) begin
            @(negedge clk);
            ha = aw_valid && aw_ready;
            hw = w_valid && w_ready;
            tick;
            if (ha) begin aw_valid = 1'b0; da = 1'b1; end
            if (hw) begin w_valid = 1'b0; dw = 1'b1; end
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("aw_w_handshake", {da, dw}, 2'b11);
    endtask

    task automatic b_wait(output logic [1:0] resp);
        logic got;
        got = 1'b0; resp = 2'b11;
        b_ready = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            if (b_valid) begin got = 1'b1; resp = b_resp; end
            tick;
        end
        b_ready = 1'b0;
        chk("b_seen", got, 1'b1);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        aw_w_send(a, d, s);
        b_wait(resp);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic done, hs, got;
        ar_valid = 1'b1; ar_addr = a;
        done = 1'b0; got = 1'b0; d = '1; resp = 2'b11;
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge clk);
            hs = ar_valid && ar_ready;
            tick;
            if (hs) begin ar_valid = 1'b0; done = 1'b1; end
        end
        ar_valid = 1'b0;
        r_ready = 1'b1;
        for (int n = 0; n < 16 && done && !got; n++) begin
            @(negedge clk);
            if (r_valid) begin got = 1'b1; d = r_data; resp = r_resp; end
            tick;
        end
        r_ready = 1'b0;
        chk("ar_r_handshake", {done, got}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, bs;
        int          wc0;

        areset = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0; interrupts = '0;
        stat = {32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
        chk("rst_valids", {b_valid, r_valid, irq}, 3'b000);
        chk("rst_resp_data", {b_resp, r_resp, r_data}, 36'h0);
        chk("rst_ctrl_lo", ctrl[63:0], CRST[63:0]);
        chk("rst_ctrl_hi", ctrl[127:64], CRST[127:64]);
        chk("rst_write_ctrl", write_ctrl, 16'h0);
        tick;
        areset = 1'b0;
        tick;
        @(negedge clk);
        chk("post_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
        tick;

        // W arrives three cycles before AW
        w_valid = 1'b1; w_data = 32'hDEAD_BEEF; w_strb = 4'h5;
        @(negedge clk);
        chk("ord_w_ready", w_ready, 1'b1);
        tick;
        w_valid = 1'b0;
        @(negedge clk);
        chk("ord_readies_after_w", {aw_ready, w_ready}, 2'b10);
        tick;
        tick;
        aw_valid = 1'b1; aw_addr = 12'h004;
        @(negedge clk);
        chk("ord_aw_ready", aw_ready, 1'b1);
        tick;
        aw_valid = 1'b0;
        @(negedge clk);
        chk("ord_commit_quiet", {b_valid, write_ctrl}, 17'h0);
        tick;
        @(negedge clk);
        chk("ord_bvalid", {b_valid, b_resp}, 3'b100);
        chk("ord_write_ctrl", write_ctrl, 16'h0050);
        chk("ord_ctrl1", ctrl[63:32], 32'h00AD_00EF);
        tick;
        @(negedge clk);
        chk("ord_write_ctrl_1cyc", {b_valid, write_ctrl}, 17'h1_0000);
        tick;
        b_ready = 1'b1;
        tick;
        b_ready = 1'b0;
        @(negedge clk);
        chk("ord_after_b", {b_valid, aw_ready, w_ready}, 3'b011);
        tick;

        // read-only and unmapped accesses
        wc0 = wc_pulses;
        axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, bs);
        chk("ro_wr_resp", bs, 2'b10);
        chk("ro_ctrl_lo", ctrl[63:0], 64'h00AD_00EF_1234_5678);
        chk("ro_ctrl_hi", ctrl[127:64], 64'h0);
        chk("ro_no_pulse", wc_pulses - wc0, 0);
        axi_write(12'h040, 32'h1, 4'hF, bs);
        chk("unmapped_wr_resp", bs, 2'b10);
        axi_write(12'h028, 32'h1, 4'hF, bs);
        chk("pend_wr_resp", bs, 2'b10);
        axi_read(12'h040, rd, rs);
        chk("unmapped_rd", {rd, rs}, {32'h0, 2'b10});
        axi_read(12'h014, rd, rs);
        chk("stat1_rd", {rd, rs}, {32'h5A00_0001, 2'b00});
        axi_read(12'h004, rd, rs);
        chk("ctrl1_rd", {rd, rs}, {32'h00AD_00EF, 2'b00});

        // level interrupt on source 0
        interrupts = 8'h01;
        tick;
        tick;
        axi_read(12'h024, rd, rs);
        chk("lvl_stat_disabled", rd, 32'h0);
        axi_write(12'h020, 32'h1, 4'hF, bs);
        chk("lvl_en_resp", bs, 2'b00);
        @(negedge clk);
        chk("lvl_irq_early", irq, 1'b0);
        tick;
        @(negedge clk);
        chk("lvl_irq", irq, 1'b1);
        tick;
        axi_write(12'h024, 32'h1, 4'hF, bs);
        axi_read(12'h024, rd, rs);
        chk("lvl_set_wins", rd, 32'h1);
        interrupts = 8'h00;
        tick;
        axi_write(12'h024, 32'h1, 4'hF, bs);
        axi_read(12'h024, rd, rs);
        chk("lvl_cleared", rd, 32'h0);
        @(negedge clk);
        chk("lvl_irq_off", irq, 1'b0);
        tick;

        // edge interrupt on source 1
        axi_write(12'h020, 32'h2, 4'hF, bs);
        interrupts = 8'h02;
        tick;
        interrupts = 8'h00;
        tick;
        tick;
        axi_read(12'h024, rd, rs);
        chk("edge_stat", rd, 32'h2);
        axi_read(12'h028, rd, rs);
        chk("edge_pend", {rd, rs}, {32'h2, 2'b00});
        @(negedge clk);
        chk("edge_irq", irq, 1'b1);
        tick;
        axi_write(12'h020, 32'h0, 4'hF, bs);
        axi_read(12'h028, rd, rs);
        chk("edge_pend_disabled", rd, 32'h0);
        axi_read(12'h024, rd, rs);
        chk("edge_stat_kept", rd, 32'h2);
        @(negedge clk);
        chk("edge_irq_off", irq, 1'b0);
        tick;
        // W1C with the relevant byte strobe clear leaves the bit
        axi_write(12'h024, 32'h2, 4'hE, bs);
        axi_read(12'h024, rd, rs);
        chk("w1c_strb_clear", rd, 32'h2);
        axi_write(12'h024, 32'h2, 4'h1, bs);
        // a held-high source produces no new event once enabled
        interrupts = 8'h02;
        tick;
        axi_write(12'h020, 32'h2, 4'hF, bs);
        tick;
        tick;
        axi_read(12'h024, rd, rs);
        chk("edge_no_level", rd, 32'h0);
        interrupts = 8'h00;
        tick;

        // read in the COMMIT cycle of a write to the same register
        axi_write(12'h008, 32'hAAAA_0000, 4'hF, bs);
        aw_w_send(12'h008, 32'h5555_1234, 4'hF);
        axi_read(12'h008, rd, rs);
        chk("conc_old", rd, 32'hAAAA_0000);
        b_wait(bs);
        chk("conc_b_resp", bs, 2'b00);
        axi_read(12'h008, rd, rs);
        chk("conc_new", rd, 32'h5555_1234);

        // reset during the RESP phase of a write
        aw_w_send(12'h000, 32'hCAFE_F00D, 4'hF);
        tick;
        areset = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp_phase", b_valid, 1'b1);
        tick;
        areset = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", {b_valid, aw_ready, w_ready, ar_ready, write_ctrl}, 20'h0);
        chk("mid_rst_ctrl_lo", ctrl[63:0], CRST[63:0]);
        chk("mid_rst_ctrl_hi", ctrl[127:64], CRST[127:64]);
        tick;
        @(negedge clk);
        chk("mid_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
        tick;
        tick;
        @(negedge clk);
        chk("mid_rst_no_b", b_valid, 1'b0);
        tick;
        axi_read(12'h000, rd, rs);
        chk("mid_rst_ctrl0_rd", {rd, rs}, {32'h1234_5678, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
